// File: rtl/set_task_dispatcher_if.sv
// Job, SET-engine and result signals of the SET task dispatcher.
// The slave modport is the dispatcher; the master modport is its surroundings.
interface set_task_dispatcher_if;
    logic        job_valid;
    logic        job_ready;
    logic [3:0]  job_id;
    logic [23:0] job_central;
    logic [11:0] job_radius;
    logic [1:0]  job_mode;
    logic        set_en;
    logic [23:0] set_central;
    logic [11:0] set_radius;
    logic [1:0]  set_mode;
    logic        set_busy;
    logic        set_valid;
    logic [7:0]  set_candidate;
    logic        res_valid;
    logic        res_ready;
    logic [3:0]  res_id;
    logic [7:0]  res_candidate;
    logic        res_err;
    logic [7:0]  done_cnt;

    modport slave (
        input  job_valid, job_id, job_central, job_radius, job_mode,
               set_busy, set_valid, set_candidate, res_ready,
        output job_ready, set_en, set_central, set_radius, set_mode,
               res_valid, res_id, res_candidate, res_err, done_cnt
    );
    modport master (
        output job_valid, job_id, job_central, job_radius, job_mode,
               set_busy, set_valid, set_candidate, res_ready,
        input  job_ready, set_en, set_central, set_radius, set_mode,
               res_valid, res_id, res_candidate, res_err, done_cnt
    );
endinterface

// File: rtl/set_task_dispatcher.sv
// Buffers tagged jobs in a FIFO, issues them one at a time to the SET engine,
// and returns tagged results; illegal modes and hung jobs come back as errors.
module set_task_dispatcher #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input logic clk,
    input logic rst,
    set_task_dispatcher_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] POST  = 2'd3;
    localparam logic [7:0] WD_MAX = 8'(TIMEOUT - 1);

    typedef struct packed {
        logic [3:0]  id;
        logic [23:0] central;
        logic [11:0] radius;
        logic [1:0]  mode;
    } job_t;

    job_t          mem [DEPTH];
    job_t          head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, empty, push, pop;

    logic [1:0] state;
    logic [7:0] wd;
    logic [3:0] tag_id;
    logic [7:0] cand_pending;
    logic       err_pending;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];
    // Push is gated on full alone, so a same-cycle pop never frees a slot early.
    assign push  = bus.job_valid && !full;
    assign pop   = (state == IDLE) && !empty && ((head.mode == 2'd3) || !bus.set_busy);
    assign bus.job_ready = !full;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {bus.job_id, bus.job_central, bus.job_radius, bus.job_mode};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            wd                <= '0;
            tag_id            <= '0;
            cand_pending      <= '0;
            err_pending       <= 1'b0;
            bus.set_en        <= 1'b0;
            bus.set_central   <= '0;
            bus.set_radius    <= '0;
            bus.set_mode      <= '0;
            bus.res_valid     <= 1'b0;
            bus.res_id        <= '0;
            bus.res_candidate <= '0;
            bus.res_err       <= 1'b0;
            bus.done_cnt      <= '0;
        end else begin
            if (bus.res_valid && bus.res_ready) bus.res_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop && head.mode == 2'd3) begin
                        tag_id       <= head.id;
                        err_pending  <= 1'b1;
                        cand_pending <= '0;
                        state        <= POST;
                    end else if (pop) begin
                        tag_id          <= head.id;
                        bus.set_central <= head.central;
                        bus.set_radius  <= head.radius;
                        bus.set_mode    <= head.mode;
                        bus.set_en      <= 1'b1;
                        state           <= ISSUE;
                    end
                end
                ISSUE: begin
                    bus.set_en <= 1'b0;
                    wd         <= '0;
                    state      <= WAIT;
                end
                WAIT: begin
                    if (bus.set_valid) begin
                        cand_pending <= bus.set_candidate;
                        err_pending  <= 1'b0;
                        state        <= POST;
                    end else if (wd == WD_MAX) begin
                        cand_pending <= '0;
                        err_pending  <= 1'b1;
                        state        <= POST;
                    end else begin
                        wd <= wd + 8'd1;
                    end
                end
                POST: begin
                    if (!bus.res_valid || bus.res_ready) begin
                        bus.res_id        <= tag_id;
                        bus.res_candidate <= cand_pending;
                        bus.res_err       <= err_pending;
                        bus.res_valid     <= 1'b1;
                        bus.done_cnt      <= bus.done_cnt + 8'd1;
                        state             <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
